// File: rtl/operand_packer_if.sv
// Byte-in / word-out bus of the operand packer: source handshake plus FIFO write side.
interface operand_packer_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [4:0]  left_sig;
    logic        write_req;
    logic [15:0] fifo_write_data;

    modport master (
        output in_valid, in_data, left_sig,
        input  in_ready, write_req, fifo_write_data
    );

    modport slave (
        input  in_valid, in_data, left_sig,
        output in_ready, write_req, fifo_write_data
    );
endinterface

// File: rtl/operand_packer.sv
// Pairs a byte stream into {multiplicand, multiplier} words for the multiplier FIFO (DROP_ZERO_EN drops zero-operand pairs).
// Latency: write_req rises two edges after the second byte is taken; at most one word every 4 cycles.
// Backpressure: in_ready low while a full pair is held; the write waits until left_sig > RESERVE.
module operand_packer #(
    parameter int unsigned RESERVE    = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    operand_packer_if.slave        bus,
    output logic [15:0]            word_cnt,
    output logic [7:0]             drop_cnt,
    output logic                   busy
);

    typedef enum logic [1:0] {S_HI, S_LO, S_CHK, S_GAP} state_t;

    localparam logic [4:0] DEPTH5 = 5'(FIFO_DEPTH);
    localparam logic [4:0] RES5   = 5'(RESERVE);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic        write_req_q, write_req_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        in_ready;
    logic        xfer;
    logic [4:0]  left_eff;
    logic        space_ok;
`ifdef DROP_ZERO_EN
    logic [7:0]  drop_cnt_q, drop_cnt_d;
`endif

    assign in_ready = (state_q == S_HI) || (state_q == S_LO);
    assign xfer     = bus.in_valid && in_ready;

    // Counts above the FIFO depth are clamped, so they always read as space available.
    assign left_eff = (bus.left_sig > DEPTH5) ? DEPTH5 : bus.left_sig;
    assign space_ok = left_eff > RES5;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        write_req_d = write_req_q;
        wdata_d     = wdata_q;
        word_cnt_d  = word_cnt_q;
`ifdef DROP_ZERO_EN
        drop_cnt_d  = drop_cnt_q;
`endif
        case (state_q)
            S_HI: begin
                if (xfer) begin
                    hi_d    = bus.in_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = bus.in_data;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
`ifdef DROP_ZERO_EN
                if ((hi_q == 8'd0) || (lo_q == 8'd0)) begin
                    state_d = S_HI;
                    if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end else
`endif
                if (space_ok) begin
                    write_req_d = 1'b1;
                    wdata_d     = {hi_q, lo_q};
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                // One idle cycle lets left_sig account for this write before the next check.
                write_req_d = 1'b0;
                word_cnt_d  = word_cnt_q + 16'd1;
                state_d     = S_HI;
            end
            default: state_d = S_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HI;
            hi_q        <= 8'd0;
            lo_q        <= 8'd0;
            write_req_q <= 1'b0;
            wdata_q     <= 16'd0;
            word_cnt_q  <= 16'd0;
`ifdef DROP_ZERO_EN
            drop_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            write_req_q <= write_req_d;
            wdata_q     <= wdata_d;
            word_cnt_q  <= word_cnt_d;
`ifdef DROP_ZERO_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.write_req       = write_req_q;
    assign bus.fifo_write_data = wdata_q;
    assign word_cnt            = word_cnt_q;
    assign busy                = (state_q != S_HI);
`ifdef DROP_ZERO_EN
    assign drop_cnt            = drop_cnt_q;
`else
    assign drop_cnt            = 8'd0;
`endif

endmodule

// File: tb/tb_operand_packer.sv
// Bench for operand_packer: queue/FIFO model checked every cycle plus directed literal checks.
module tb_operand_packer;

    localparam int RES = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_packer_if pif ();
    operand_packer_if rif ();

    logic [15:0] word_cnt, r_word_cnt;
    logic [7:0]  drop_cnt, r_drop_cnt;
    logic        busy, r_busy;

    operand_packer #(.RESERVE(RES), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(pif),
        .word_cnt(word_cnt), .drop_cnt(drop_cnt), .busy(busy)
    );

    operand_packer #(.RESERVE(2), .FIFO_DEPTH(16)) dut_r (
        .clk(clk), .rst_n(rst_n), .bus(rif),
        .word_cnt(r_word_cnt), .drop_cnt(r_drop_cnt), .busy(r_busy)
    );

    int checks = 0;
    int failures = 0;

    // FIFO model: occupancy grows on each observed write; the bench "drains" by moving the base.
    int          fifo_cnt = 0;
    int          fifo_base = 0;
    bit          force_en = 1'b0;
    logic [4:0]  force_left = 5'd16;
    logic [15:0] exp_q[$];

    assign pif.left_sig = force_en ? force_left :
                          ((fifo_cnt - fifo_base) >= 16) ? 5'd0 : 5'(16 - (fifo_cnt - fifo_base));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle model: bytes accepted vs pairs retired decide in_ready/busy; writes must match queue order.
    int          acc = 0;
    int          ret = 0;
    int unsigned model_cnt = 0;
    bit          prev_xfer = 1'b0;
    bit          prev_wr = 1'b0;
    logic [4:0]  prev_left = 5'd0;

    always @(negedge clk) begin
        if (!rst_n) begin
            acc = 0; ret = 0; model_cnt = 0;
            prev_xfer = 1'b0; prev_wr = 1'b0;
            exp_q.delete();
            chk("rst_write_req", 32'(pif.write_req), 32'd0);
            chk("rst_wdata", 32'(pif.fifo_write_data), 32'd0);
            chk("rst_word_cnt", 32'(word_cnt), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        end else begin
            if (prev_xfer) acc++;
            if (prev_wr) begin model_cnt++; ret++; end
`ifndef DROP_ZERO_EN
            chk("in_ready", 32'(pif.in_ready), 32'((acc - 2*ret) < 2));
            chk("busy", 32'(busy), 32'((acc - 2*ret) != 0));
            chk("drop_cnt", 32'(drop_cnt), 32'd0);
`endif
            chk("word_cnt", 32'(word_cnt), 32'(model_cnt[15:0]));
            if (pif.write_req) begin
                chk("write_pulse_width", 32'(prev_wr), 32'd0);
                chk("space_at_write", 32'(32'(prev_left) > RES), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: got %0h expected no write at %0t",
                             pif.fifo_write_data, $time);
                end else begin
                    chk("wdata", 32'(pif.fifo_write_data), 32'(exp_q.pop_front()));
                end
                fifo_cnt++;
            end
        end
        prev_xfer = pif.in_valid && pif.in_ready;
        prev_wr   = pif.write_req;
        prev_left = pif.left_sig;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        pif.in_valid = 1'b1;
        pif.in_data  = b;
        @(negedge clk);
        while (!pif.in_ready && n < 100) begin n++; @(negedge clk); end
        if (!pif.in_ready) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready=0 expected 1 for byte %0h", b);
        end
        @(posedge clk);
        #1 pif.in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] h, input logic [7:0] l);
        send_byte(h);
        send_byte(l);
`ifdef DROP_ZERO_EN
        if (h != 8'd0 && l != 8'd0) exp_q.push_back({h, l});
`else
        exp_q.push_back({h, l});
`endif
    endtask

    task automatic wait_write(input string name, input logic [15:0] exp);
        int n = 0;
        @(negedge clk);
        while (!pif.write_req && n < 40) begin n++; @(negedge clk); end
        chk(name, 32'(pif.write_req ? pif.fifo_write_data : 16'hXXXX), 32'(exp));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pif.in_valid = 1'b0;
        rif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        pif.in_valid = 1'b0; pif.in_data = 8'd0;
        rif.in_valid = 1'b0; rif.in_data = 8'd0; rif.left_sig = 5'd2;
        do_reset();
        @(negedge clk);
        chk("post_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("post_rst_in_ready", 32'(pif.in_ready), 32'd1);
        @(posedge clk); #1;

        // Single pair: write two edges after second byte.
        send_pair(8'h12, 8'h34);
        @(negedge clk);
        chk("t1_chk_wr", 32'(pif.write_req), 32'd0);
        chk("t1_chk_ready", 32'(pif.in_ready), 32'd0);
        @(negedge clk);
        chk("t1_gap_wr", 32'(pif.write_req), 32'd1);
        chk("t1_gap_data", 32'(pif.fifo_write_data), 32'h1234);
        chk("t1_gap_ready", 32'(pif.in_ready), 32'd0);
        @(negedge clk);
        chk("t1_after_wr", 32'(pif.write_req), 32'd0);
        chk("t1_word_cnt", 32'(word_cnt), 32'd1);
        chk("t1_hold_data", 32'(pif.fifo_write_data), 32'h1234);
        @(posedge clk); #1;

        // FIFO full: stall until left_sig rises.
        force_en = 1'b1; force_left = 5'd0;
        send_pair(8'hAB, 8'hCD);
        repeat (6) begin
            @(negedge clk);
            chk("t2_stall_wr", 32'(pif.write_req), 32'd0);
        end
        chk("t2_stall_ready", 32'(pif.in_ready), 32'd0);
        chk("t2_stall_busy", 32'(busy), 32'd1);
        @(posedge clk); #1 force_left = 5'd3;
        @(negedge clk);
        chk("t2_sample_wr", 32'(pif.write_req), 32'd0);
        @(negedge clk);
        chk("t2_wr", 32'(pif.write_req), 32'd1);
        chk("t2_data", 32'(pif.fifo_write_data), 32'hABCD);
        @(posedge clk); #1 force_en = 1'b0; fifo_base = fifo_cnt;

        // RESERVE=2 instance: left_sig=2 stalls, 3 writes.
        rif.in_valid = 1'b1; rif.in_data = 8'h5A;
        @(negedge clk);
        chk("t3_ready_hi", 32'(rif.in_ready), 32'd1);
        @(posedge clk); #1 rif.in_data = 8'hA5;
        @(negedge clk);
        chk("t3_ready_lo", 32'(rif.in_ready), 32'd1);
        @(posedge clk); #1 rif.in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t3_stall_wr", 32'(rif.write_req), 32'd0);
        end
        chk("t3_stall_busy", 32'(r_busy), 32'd1);
        @(posedge clk); #1 rif.left_sig = 5'd3;
        @(negedge clk);
        chk("t3_sample_wr", 32'(rif.write_req), 32'd0);
        @(negedge clk);
        chk("t3_wr", 32'(rif.write_req), 32'd1);
        chk("t3_data", 32'(rif.fifo_write_data), 32'h5AA5);
        @(negedge clk);
        chk("t3_word_cnt", 32'(r_word_cnt), 32'd1);
        @(posedge clk); #1;

        // Fill a 16-deep FIFO: 16 writes, 17th pair stalls until drained.
        fifo_base = fifo_cnt;
        for (int i = 0; i < 16; i++) send_pair(8'(i + 16), 8'(i * 3 + 1));
        send_pair(8'hEE, 8'h11);
        repeat (8) @(negedge clk);
        chk("t4_word_cnt_full", 32'(word_cnt), 32'd18);
        chk("t4_full_busy", 32'(busy), 32'd1);
        chk("t4_full_ready", 32'(pif.in_ready), 32'd0);
        chk("t4_full_wr", 32'(pif.write_req), 32'd0);
        @(posedge clk); #1 fifo_base = fifo_cnt;
        wait_write("t4_drain_data", 16'hEE11);
        @(negedge clk);
        chk("t4_word_cnt_drain", 32'(word_cnt), 32'd19);
        @(posedge clk); #1;

        // Reset mid-pair and mid-write.
        send_byte(8'h55);
        do_reset();
        @(negedge clk);
        chk("t5_busy_after_rst", 32'(busy), 32'd0);
        @(posedge clk); #1 fifo_base = fifo_cnt;
        send_pair(8'h66, 8'h77);
        wait_write("t5_pre_rst_data", 16'h6677);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_async_wr", 32'(pif.write_req), 32'd0);
        chk("t5_async_word_cnt", 32'(word_cnt), 32'd0);
        do_reset();
        fifo_base = fifo_cnt;
        send_pair(8'h01, 8'h02);
        wait_write("t5_post_rst_data", 16'h0102);
        @(negedge clk);
        chk("t5_word_cnt", 32'(word_cnt), 32'd1);
        @(posedge clk); #1;

        // Zero operands.
        fifo_base = fifo_cnt;
        send_pair(8'h00, 8'h07);
        send_pair(8'h03, 8'h04);
        repeat (10) @(negedge clk);
`ifdef DROP_ZERO_EN
        chk("t6_word_cnt", 32'(word_cnt), 32'd2);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd1);
`else
        chk("t6_word_cnt", 32'(word_cnt), 32'd3);
        chk("t6_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
